// File: rtl/clock_mode_ctrl.sv
// Front-panel controller: debounces the four raw buttons, sequences the
// run/set mode FSM, gates edit pulses to the active setter and auto-aborts on inactivity.
module clock_mode_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int TIMEOUT_S  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_next,
  output logic [1:0] clk_mode,
  output logic       pulse_a,
  output logic       pulse_b,
  output logic       pulse_next,
  output logic [1:0] field_idx,
  output logic       blink,
  output logic       commit,
  output logic       abort
);

  typedef enum logic [1:0] {
    MODE_RUN       = 2'b00,
    MODE_SET_TIME  = 2'b01,
    MODE_SET_ALARM = 2'b10,
    MODE_SET_DATE  = 2'b11
  } mode_e;

  localparam int             CW         = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(DEB_CYCLES - 1);
  localparam logic [7:0]     INACT_LAST = 8'(TIMEOUT_S - 1);

  // Button vector order: [0] mode, [1] a, [2] b, [3] next
  logic [3:0]    raw_s;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    db_q, db_d, db_prev_q;
  logic [3:0]    rise_s;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  mode_e      mode_q, mode_d;
  logic [1:0] field_q, field_d;
  logic [7:0] inact_q, inact_d;
  logic       blink_q, blink_d;
  logic [2:0] pulse_q, pulse_d;
  logic       commit_pend_q, commit_pend_d, commit_q;
  logic       abort_pend_q, abort_pend_d, abort_q;
  logic       any_press_s, timeout_s;

  function automatic logic [1:0] field_last(input mode_e m);
    case (m)
      MODE_SET_TIME:  field_last = 2'd2;
      MODE_SET_ALARM: field_last = 2'd1;
      MODE_SET_DATE:  field_last = 2'd3;
      default:        field_last = 2'd0;
    endcase
  endfunction

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_RUN:       next_mode = MODE_SET_TIME;
      MODE_SET_TIME:  next_mode = MODE_SET_ALARM;
      MODE_SET_ALARM: next_mode = MODE_SET_DATE;
      default:        next_mode = MODE_RUN;
    endcase
  endfunction

  assign raw_s       = {btn_next, btn_b, btn_a, btn_mode};
  assign rise_s      = db_q & ~db_prev_q;
  assign any_press_s = |rise_s;
  // A press in the same cycle keeps the editor alive, so it beats expiry
  assign timeout_s   = tick_1hz & ~any_press_s & (inact_q == INACT_LAST);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 4'b0000;
      sync2_q   <= 4'b0000;
      db_q      <= 4'b0000;
      db_prev_q <= 4'b0000;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw_s;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    mode_d        = mode_q;
    field_d       = field_q;
    inact_d       = inact_q;
    blink_d       = blink_q;
    pulse_d       = 3'b000;
    commit_pend_d = 1'b0;
    abort_pend_d  = 1'b0;
    if (mode_q == MODE_RUN) begin
      field_d = 2'd0;
      inact_d = 8'd0;
      if (rise_s[0]) begin
        mode_d  = MODE_SET_TIME;
        blink_d = 1'b1;
      end else begin
        blink_d = 1'b0;
      end
    end else if (rise_s[0]) begin
      // Mode press wins over edit presses and over a coinciding expiry
      mode_d        = next_mode(mode_q);
      field_d       = 2'd0;
      inact_d       = 8'd0;
      blink_d       = (next_mode(mode_q) != MODE_RUN);
      commit_pend_d = 1'b1;
    end else if (timeout_s) begin
      mode_d       = MODE_RUN;
      field_d      = 2'd0;
      inact_d      = 8'd0;
      blink_d      = 1'b0;
      abort_pend_d = 1'b1;
    end else begin
      pulse_d = rise_s[3:1];
      if (any_press_s) begin
        inact_d = 8'd0;
      end else if (tick_1hz) begin
        inact_d = inact_q + 8'd1;
      end else begin
        inact_d = inact_q;
      end
      if (tick_1hz) begin
        blink_d = ~blink_q;
      end else begin
        blink_d = blink_q;
      end
      if (rise_s[3]) begin
        field_d = (field_q == field_last(mode_q)) ? 2'd0 : field_q + 2'd1;
      end else begin
        field_d = field_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q        <= MODE_RUN;
      field_q       <= 2'd0;
      inact_q       <= 8'd0;
      blink_q       <= 1'b0;
      pulse_q       <= 3'b000;
      commit_pend_q <= 1'b0;
      commit_q      <= 1'b0;
      abort_pend_q  <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      field_q       <= field_d;
      inact_q       <= inact_d;
      blink_q       <= blink_d;
      pulse_q       <= pulse_d;
      commit_pend_q <= commit_pend_d;
      commit_q      <= commit_pend_q;
      abort_pend_q  <= abort_pend_d;
      abort_q       <= abort_pend_q;
    end
  end

  assign clk_mode   = mode_q;
  assign field_idx  = field_q;
  assign blink      = blink_q;
  assign pulse_a    = pulse_q[0];
  assign pulse_b    = pulse_q[1];
  assign pulse_next = pulse_q[2];
  assign commit     = commit_q;
  assign abort      = abort_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl: every stimulus pushes the output events it
// should cause (cycle, mode, field, blink, strobes); a negedge monitor pops and compares.
module tb_clock_mode_ctrl;

  localparam int DEB = 4;
  localparam int TO  = 3;

  logic       clk = 1'b0;
  logic       rst, tick_1hz, btn_mode, btn_a, btn_b, btn_next;
  logic [1:0] clk_mode, field_idx;
  logic       pulse_a, pulse_b, pulse_next, blink, commit, abort;

  clock_mode_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT_S(TO)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_a(btn_a), .btn_b(btn_b), .btn_next(btn_next),
    .clk_mode(clk_mode), .pulse_a(pulse_a), .pulse_b(pulse_b), .pulse_next(pulse_next),
    .field_idx(field_idx), .blink(blink), .commit(commit), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int mode;
    int field;
    int blk;
    int ev;   // {pulse_a, pulse_b, pulse_next, commit, abort}
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   m_mode, m_field, m_blink, m_inact;
  logic [1:0] pm, pf;
  logic       pbk;
  logic [4:0] ev_w;
  exp_t       e_mon;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int md, input int f, input int b, input int ev);
    sb.push_back('{c, md, f, b, ev});
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      ev_w = {pulse_a, pulse_b, pulse_next, commit, abort};
      if (clk_mode != pm || field_idx != pf || blink != pbk || ev_w != 5'd0) begin
        if (sb.size() > 0) e_mon = sb.pop_front();
        else e_mon = '{-1, 0, 0, 0, 0};
        chk("ev_cycle", cyc, e_mon.cyc);
        chk("ev_mode", int'(clk_mode), e_mon.mode);
        chk("ev_field", int'(field_idx), e_mon.field);
        chk("ev_blink", int'(blink), e_mon.blk);
        chk("ev_strobes", int'(ev_w), e_mon.ev);
      end
      pm  = clk_mode;
      pf  = field_idx;
      pbk = blink;
    end
  end

  // mask bits: [0] mode, [1] a, [2] b, [3] next; with_tick lands a tick on the press edge
  task automatic press(input logic [3:0] mask, input bit with_tick);
    int c, e, nm, ev;
    c = cyc;
    e = c + DEB + 3;
    {btn_next, btn_b, btn_a, btn_mode} = mask;
    if (mask[0]) begin
      nm = (m_mode + 1) % 4;
      push(e, nm, 0, (nm != 0) ? 1 : 0, 0);
      if (m_mode != 0) push(e + 1, nm, 0, (nm != 0) ? 1 : 0, 5'b00010);
      m_mode  = nm;
      m_field = 0;
      m_inact = 0;
      m_blink = (nm != 0) ? 1 : 0;
    end else if (m_mode != 0) begin
      ev = {mask[1], mask[2], mask[3], 2'b00};
      if (mask[3]) begin
        case (m_mode)
          1: m_field = (m_field + 1) % 3;
          2: m_field = (m_field + 1) % 2;
          default: m_field = (m_field + 1) % 4;
        endcase
      end
      m_inact = 0;
      push(e, m_mode, m_field, m_blink, ev);
    end
    for (int i = 0; i < DEB + 8; i++) begin
      @(negedge clk);
      tick_1hz = (with_tick && cyc == e - 1);
    end
    {btn_next, btn_b, btn_a, btn_mode} = 4'b0000;
    repeat (DEB + 6) @(negedge clk);
  endtask

  task automatic tick_pulse();
    int t;
    t = cyc;
    tick_1hz = 1'b1;
    if (m_mode != 0) begin
      if (m_inact + 1 == TO) begin
        push(t + 1, 0, 0, 0, 0);
        push(t + 2, 0, 0, 0, 5'b00001);
        m_mode = 0; m_field = 0; m_blink = 0; m_inact = 0;
      end else begin
        m_inact++;
        m_blink = 1 - m_blink;
        push(t + 1, m_mode, m_field, m_blink, 0);
      end
    end
    @(negedge clk);
    tick_1hz = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic bounce_a();
    int c;
    btn_a = 1'b1; @(negedge clk);
    btn_a = 1'b0; @(negedge clk);
    btn_a = 1'b1; @(negedge clk);
    btn_a = 1'b0; @(negedge clk);
    c = cyc;
    btn_a = 1'b1;
    push(c + DEB + 3, m_mode, m_field, m_blink, 5'b10000);
    m_inact = 0;
    repeat (DEB + 12) @(negedge clk);
    btn_a = 1'b0;
    repeat (DEB + 6) @(negedge clk);
  endtask

  task automatic glitch_a();
    btn_a = 1'b1;
    repeat (DEB - 1) @(negedge clk);
    btn_a = 1'b0;
    repeat (DEB + 8) @(negedge clk);
  endtask

  task automatic reset_mid_edit();
    int r, r2;
    r = cyc;
    rst = 1'b1;
    btn_mode = 1'b1;
    push(r + 1, 0, 0, 0, 0);
    m_mode = 0; m_field = 0; m_blink = 0; m_inact = 0;
    repeat (3) @(negedge clk);
    r2 = cyc;
    rst = 1'b0;
    push(r2 + DEB + 3, 1, 0, 1, 0);
    m_mode = 1; m_blink = 1;
    repeat (DEB + 8) @(negedge clk);
    btn_mode = 1'b0;
    repeat (DEB + 6) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0;
    btn_mode = 1'b0; btn_a = 1'b0; btn_b = 1'b0; btn_next = 1'b0;
    m_mode = 0; m_field = 0; m_blink = 0; m_inact = 0;
    repeat (3) @(negedge clk);
    chk("rst_mode", int'(clk_mode), 0);
    chk("rst_field", int'(field_idx), 0);
    chk("rst_blink", int'(blink), 0);
    chk("rst_commit", int'(commit), 0);
    chk("rst_abort", int'(abort), 0);
    chk("rst_pulses", int'({pulse_a, pulse_b, pulse_next}), 0);
    pm = 2'd0; pf = 2'd0; pbk = 1'b0;
    mon_en = 1'b1;
    rst = 1'b0;

    press(4'b1000, 1'b0);
    chk("run_field", int'(field_idx), 0);
    press(4'b0010, 1'b0);
    tick_pulse();

    repeat (4) press(4'b0001, 1'b0);

    repeat (3) press(4'b0001, 1'b0);
    repeat (5) press(4'b1000, 1'b0);

    repeat (3) press(4'b0001, 1'b0);
    repeat (3) press(4'b1000, 1'b0);

    repeat (3) press(4'b0001, 1'b0);
    bounce_a();
    glitch_a();
    press(4'b0100, 1'b0);

    repeat (3) tick_pulse();

    press(4'b0001, 1'b0);
    repeat (2) tick_pulse();
    press(4'b0010, 1'b0);
    repeat (3) tick_pulse();

    press(4'b0001, 1'b0);
    press(4'b0011, 1'b0);

    repeat (2) tick_pulse();
    press(4'b0001, 1'b1);

    repeat (2) press(4'b1000, 1'b0);
    chk("pre_rst_field", int'(field_idx), 2);
    chk("pre_rst_blink", int'(blink), 1);
    reset_mid_edit();

    repeat (20) @(negedge clk);
    chk("sb_pending", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
